// File: rtl/gate_bist.sv
// Exhaustive-sweep self-test engine for small combinational gates.
// Drives every input pattern, samples the gate output and checks it against TRUTH.
module gate_bist #(
    parameter int                    N_IN   = 2,
    parameter logic [2**N_IN-1:0]    TRUTH  = 4'b1000,
    parameter int                    SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            dut_y,
    output logic [N_IN-1:0] pattern,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] fail_index
);

    localparam int              CW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   RELOAD = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] LAST   = '1;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   settle_cnt;
    logic [N_IN:0]   err_cnt;
    logic            first_seen;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pattern    <= '0;
            settle_cnt <= RELOAD;
            err_cnt    <= '0;
            fail_index <= '0;
            first_seen <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // IDLE keeps results cleared; DONE holds them until a new start
                    if (state == IDLE || start) begin
                        pattern    <= '0;
                        err_cnt    <= '0;
                        fail_index <= '0;
                        first_seen <= 1'b0;
                        settle_cnt <= RELOAD;
                    end
                    if (start) begin
                        state <= DRIVE;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (settle_cnt == '0) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                SAMPLE: begin
                    if (dut_y != TRUTH[pattern]) begin
                        err_cnt <= err_cnt + 1'b1;
                        if (!first_seen) begin
                            fail_index <= pattern;
                            first_seen <= 1'b1;
                        end
                    end
                    if (pattern == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        pattern    <= pattern + 1'b1;
                        settle_cnt <= RELOAD;
                        state      <= DRIVE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign err_count = err_cnt;
    assign pass      = done && (err_cnt == '0);

endmodule

// File: tb/tb_gate_bist.sv
// Scoreboard bench for gate_bist: two instances (SETTLE=1 and SETTLE=3) share a
// behavioural gate model selected by mode; a monitor checks each finished sweep.
module tb_gate_bist;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b;
    logic       dy_a, dy_b;
    logic [1:0] pat_a, pat_b;
    logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [2:0] ec_a, ec_b;
    logic [1:0] fi_a, fi_b;

    always #5 clk = ~clk;

    gate_bist #(.N_IN(2), .TRUTH(4'b1000), .SETTLE(1)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .dut_y(dy_a), .pattern(pat_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(ec_a), .fail_index(fi_a)
    );

    gate_bist #(.N_IN(2), .TRUTH(4'b1000), .SETTLE(3)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .dut_y(dy_b), .pattern(pat_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(ec_b), .fail_index(fi_b)
    );

    // 0: ideal AND, 1: stuck-at-0, 2: OR gate, 3: AND but inverted outside SAMPLE
    int mode = 0;

    function automatic logic gate_out(input int m, input logic [1:0] p, input bit in_sample);
        logic good;
        good = p[1] & p[0];
        case (m)
            1:       gate_out = 1'b0;
            2:       gate_out = p[1] | p[0];
            3:       gate_out = in_sample ? good : ~good;
            default: gate_out = good;
        endcase
    endfunction

    // Cycle index within the current pattern of instance b; index SETTLE is the sample cycle
    int         hold_b = 0;
    logic       hb_prev_busy = 1'b0;
    logic [1:0] hb_last = 2'd0;
    always @(posedge clk) begin
        #1;
        if (busy_b && hb_prev_busy && pat_b == hb_last) hold_b++;
        else hold_b = 0;
        hb_prev_busy = busy_b;
        hb_last      = pat_b;
    end

    assign dy_a = gate_out(mode, pat_a, 1'b1);
    assign dy_b = gate_out(mode, pat_b, hold_b == 3);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int err;
        int fidx;
        int ps;
        int busy_cyc;
        int aborted;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int   busy_cnt[2];
    bit   seq_bad[2];
    logic prev_busy[2];
    logic prev_done[2];

    task automatic mon(input int i, input logic bz, input logic dn, input logic ps,
                       input logic [2:0] ec, input logic [1:0] fi, input logic [1:0] pat);
        exp_t e;
        int   st;
        bit   have;
        st = (i == 0) ? 1 : 3;
        if (bz && !prev_busy[i]) begin
            busy_cnt[i] = 0;
            seq_bad[i]  = 1'b0;
        end
        if (bz) begin
            if (int'(pat) != busy_cnt[i] / (st + 1)) seq_bad[i] = 1'b1;
            busy_cnt[i]++;
        end
        if ((dn && !prev_done[i]) || (!bz && prev_busy[i] && !dn)) begin
            have = (i == 0) ? (q_a.size() > 0) : (q_b.size() > 0);
            chk($sformatf("inst%0d expected_entry_present", i), int'(have), 1);
            if (have) begin
                e = (i == 0) ? q_a.pop_front() : q_b.pop_front();
                if (dn) begin
                    chk($sformatf("inst%0d aborted", i), 0, e.aborted);
                    chk($sformatf("inst%0d err_count", i), int'(ec), e.err);
                    chk($sformatf("inst%0d fail_index", i), int'(fi), e.fidx);
                    chk($sformatf("inst%0d pass", i), int'(ps), e.ps);
                    chk($sformatf("inst%0d busy_cycles", i), busy_cnt[i], e.busy_cyc);
                    chk($sformatf("inst%0d pattern_sequence_ok", i), int'(seq_bad[i]), 0);
                    chk($sformatf("inst%0d done_right_after_busy", i), int'(prev_busy[i]), 1);
                end else begin
                    chk($sformatf("inst%0d aborted", i), 1, e.aborted);
                    chk($sformatf("inst%0d abort_outputs", i), int'({pat, ec, fi, ps, dn}), 0);
                end
            end
        end
        prev_busy[i] = bz;
        prev_done[i] = dn;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            busy_cnt[i] = 0; seq_bad[i] = 1'b0; prev_busy[i] = 1'b0; prev_done[i] = 1'b0;
        end
    end

    always @(negedge clk) begin
        mon(0, busy_a, done_a, pass_a, ec_a, fi_a, pat_a);
        mon(1, busy_b, done_b, pass_b, ec_b, fi_b, pat_b);
    end

    function automatic exp_t mk(input int err, input int fidx, input int ps, input int bc, input int ab);
        exp_t e;
        e.err = err; e.fidx = fidx; e.ps = ps; e.busy_cyc = bc; e.aborted = ab;
        return e;
    endfunction

    task automatic pulse_a();
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
    endtask

    task automatic pulse_b();
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
    endtask

    task automatic wait_done(input int i, input int limit);
        int n;
        n = 0;
        while (((i == 0) ? done_a : done_b) !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("inst%0d done_within_budget", i), int'(n < limit), 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs_a", int'({pat_a, busy_a, done_a, pass_a, ec_a, fi_a}), 0);
        chk("reset_outputs_b", int'({pat_b, busy_b, done_b, pass_b, ec_b, fi_b}), 0);

        // Ideal AND, defaults
        mode = 0; q_a.push_back(mk(0, 0, 1, 8, 0));
        pulse_a();
        chk("start_latency_busy", int'(busy_a), 1);
        chk("start_latency_pattern", int'(pat_a), 0);
        wait_done(0, 40);

        // Stuck-at-0
        mode = 1; q_a.push_back(mk(1, 3, 0, 8, 0));
        pulse_a(); wait_done(0, 40);

        // OR gate as DUT
        mode = 2; q_a.push_back(mk(2, 1, 0, 8, 0));
        pulse_a(); wait_done(0, 40);

        // SETTLE=3, ideal, then wrong outside the sample cycle
        mode = 0; q_b.push_back(mk(0, 0, 1, 16, 0));
        pulse_b(); wait_done(1, 60);
        mode = 3; q_b.push_back(mk(0, 0, 1, 16, 0));
        pulse_b(); wait_done(1, 60);

        // Start re-pulsed mid-sweep is ignored
        mode = 0; q_a.push_back(mk(0, 0, 1, 8, 0));
        pulse_a();
        repeat (2) @(negedge clk);
        pulse_a();
        wait_done(0, 40);

        // Reset at pattern 2, then a fresh run
        q_a.push_back(mk(0, 0, 0, 0, 1));
        pulse_a();
        n = 0;
        while (pat_a != 2'd2 && n < 20) begin @(negedge clk); n++; end
        chk("reached_pattern_2", int'(n < 20), 1);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("mid_reset_outputs", int'({pat_a, busy_a, done_a, pass_a, ec_a, fi_a}), 0);
        repeat (2) @(negedge clk);
        chk("stays_idle_after_reset", int'({busy_a, done_a}), 0);
        q_a.push_back(mk(0, 0, 1, 8, 0));
        pulse_a(); wait_done(0, 40);

        // Restart from a failing DONE with an ideal DUT
        mode = 1; q_a.push_back(mk(1, 3, 0, 8, 0));
        pulse_a(); wait_done(0, 40);
        mode = 0; q_a.push_back(mk(0, 0, 1, 8, 0));
        pulse_a();
        chk("restart_done_dropped", int'(done_a), 0);
        chk("restart_busy_rose", int'(busy_a), 1);
        chk("restart_results_cleared", int'({pat_a, ec_a, fi_a}), 0);
        wait_done(0, 40);

        repeat (3) @(negedge clk);
        chk("queue_a_drained", q_a.size(), 0);
        chk("queue_b_drained", q_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
